// File: rtl/boot_mem_pkg.sv
// Shared definitions for the boot memory: default geometry, the reset image
// and the access classification used between the decoder and the storage.
package boot_mem_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_ROM_WORDS = 7;

  // Outcome of one bus cycle as seen by the storage array.
  typedef enum logic [1:0] {
    ACC_NONE,  // idle cycle
    ACC_RD,    // legal read
    ACC_WR,    // legal write
    ACC_ERR    // illegal access (ROM write or out of range)
  } acc_e;

  // Reset contents of word idx; the caller resizes it to its own word width.
  function automatic logic [15:0] boot_image(input int unsigned idx);
    case (idx)
      0:       return 16'hF200;
      1:       return 16'h4000;
      2:       return 16'hF800;
      3:       return 16'hF400;
      4:       return 16'hB007;
      5:       return 16'h6007;
      6:       return 16'h4000;
      7:       return 16'h000F;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/boot_mem_decode.sv
// Classifies one bus request (cs/we/addr, plus the patch lock when
// BOOT_PATCH_EN is defined) into an access result. Purely combinational.
module boot_mem_decode
  import boot_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
`ifdef BOOT_PATCH_EN
  input  logic              lock,
`endif
  output acc_e              acc
);

  logic in_range;
  logic is_rom;
  logic rom_locked;

  assign in_range = 32'(addr) < DEPTH;
  assign is_rom   = 32'(addr) < ROM_WORDS;

`ifdef BOOT_PATCH_EN
  assign rom_locked = lock;
`else
  assign rom_locked = 1'b1;
`endif

  // Priority: out of range beats everything, then read, then the ROM guard.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves acc unassigned and infers a latch.
    acc = ACC_NONE;
    if (cs) begin
      if (!in_range)                acc = ACC_ERR;
      else if (!we)                 acc = ACC_RD;
      else if (is_rom && rom_locked) acc = ACC_ERR;
      else                          acc = ACC_WR;
    end
  end

endmodule

// File: rtl/boot_mem.sv
// Boot memory: flop-based single-port word store whose low ROM_WORDS words
// hold the read-only boot image and whose upper words are writable scratch.
// Read data is registered (1-cycle latency) with an rvalid strobe; illegal
// accesses pulse err. Optional macro BOOT_PATCH_EN adds a patch_lock input:
// ROM words stay writable until the sticky lock is set.
module boot_mem
  import boot_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef BOOT_PATCH_EN
  input  logic              patch_lock,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              err
);

  if (!((ROM_WORDS <= DEPTH) && (DEPTH <= (32'd1 << ADDR_W)))) begin : g_bad_cfg
    $fatal(1, "boot_mem: configuration needs ROM_WORDS <= DEPTH <= 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  acc_e              acc;

`ifdef BOOT_PATCH_EN
  logic lock_q;

  // Sticky lock: set by any patch_lock cycle, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lock_q <= 1'b0;
    else if (patch_lock) lock_q <= 1'b1;
  end
`endif

  boot_mem_decode #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .ROM_WORDS (ROM_WORDS)
  ) u_decode (
    .cs   (cs),
    .we   (we),
    .addr (addr),
`ifdef BOOT_PATCH_EN
    .lock (lock_q),
`endif
    .acc  (acc)
  );

  // Next-state of the read port: dout holds unless a read (legal or not) occurs.
  always_comb begin
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (acc)
      ACC_RD: begin
        dout_d   = mem_q[addr];
        rvalid_d = 1'b1;
      end
      ACC_ERR: begin
        err_d = 1'b1;
        if (!we) begin
          dout_d   = '0;
          rvalid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage and output registers; reset reloads the whole boot image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset on purpose -- the image lives in flops, so reset is what loads it.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(boot_image(i));
      end
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      if (acc == ACC_WR) mem_q[addr] <= din;
    end
  end

  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_boot_mem.sv
// Self-checking bench for boot_mem: a 16-word instance and a 12-word instance
// share the bus; a rules-level model tracks both. Table vectors, hand-written
// corner sequences and random traffic are all checked against it.
module tb_boot_mem;

`ifdef BOOT_PATCH_EN
  localparam bit PATCH = 1'b1;
`else
  localparam bit PATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we, plock;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout_b, dout_s;
  logic        rv_b, rv_s, er_b, er_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  boot_mem u_big (
    .clk (clk), .rst_n (rst_n), .cs (cs), .we (we), .addr (addr), .din (din),
`ifdef BOOT_PATCH_EN
    .patch_lock (plock),
`endif
    .dout (dout_b), .rvalid (rv_b), .err (er_b)
  );

  boot_mem #(.DEPTH(12)) u_small (
    .clk (clk), .rst_n (rst_n), .cs (cs), .we (we), .addr (addr), .din (din),
`ifdef BOOT_PATCH_EN
    .patch_lock (plock),
`endif
    .dout (dout_s), .rvalid (rv_s), .err (er_s)
  );

  // ---------------- reference model ----------------
  logic [15:0] IMAGE [16] = '{16'hF200, 16'h4000, 16'hF800, 16'hF400,
                              16'hB007, 16'h6007, 16'h4000, 16'h000F,
                              16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  int          depth_of [2] = '{16, 12};
  logic [15:0] mdl_mem  [2][16];
  logic [15:0] mdl_dout [2];
  logic        mdl_rv   [2];
  logic        mdl_er   [2];
  logic        mdl_lock [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mdl_mem[k][i] = IMAGE[i];
      mdl_dout[k] = '0; mdl_rv[k] = 1'b0; mdl_er[k] = 1'b0; mdl_lock[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic c, input logic w, input logic [3:0] a,
                            input logic [15:0] d, input logic pl);
    for (int k = 0; k < 2; k++) begin
      bit rom_writable;
      rom_writable = PATCH && !mdl_lock[k];
      mdl_rv[k] = 1'b0;
      mdl_er[k] = 1'b0;
      if (c) begin
        if (int'(a) >= depth_of[k]) begin
          mdl_er[k] = 1'b1;
          if (!w) begin mdl_rv[k] = 1'b1; mdl_dout[k] = '0; end
        end else if (w) begin
          if (a < 7 && !rom_writable) mdl_er[k] = 1'b1;
          else mdl_mem[k][a] = d;
        end else begin
          mdl_dout[k] = mdl_mem[k][a];
          mdl_rv[k]   = 1'b1;
        end
      end
      if (pl) mdl_lock[k] = 1'b1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("big.dout",     32'(dout_b), 32'(mdl_dout[0]));
    check("big.rvalid",   32'(rv_b),   32'(mdl_rv[0]));
    check("big.err",      32'(er_b),   32'(mdl_er[0]));
    check("small.dout",   32'(dout_s), 32'(mdl_dout[1]));
    check("small.rvalid", 32'(rv_s),   32'(mdl_rv[1]));
    check("small.err",    32'(er_s),   32'(mdl_er[1]));
  endtask

  // One bus cycle: drive, advance the model, sample #1 after the edge.
  task automatic cycle(input logic c, input logic w, input logic [3:0] a,
                       input logic [15:0] d, input logic pl);
    cs = c; we = w; addr = a; din = d; plock = pl;
    model_step(c, w, a, d, pl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle, while the current inputs are live.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        c, w;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] e_dout;
    logic        e_rv, e_err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic c, input logic w, input logic [3:0] a,
                              input logic [15:0] d, input logic [15:0] e_dout,
                              input logic e_rv, input logic e_err);
    vec_t v;
    v.c = c; v.w = w; v.a = a; v.d = d; v.e_dout = e_dout; v.e_rv = e_rv; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1, 0, 0, 16'h0,    16'hF200, 1, 0);
    vecs[1]  = mk(1, 0, 1, 16'h0,    16'h4000, 1, 0);
    vecs[2]  = mk(1, 0, 2, 16'h0,    16'hF800, 1, 0);
    vecs[3]  = mk(1, 0, 3, 16'h0,    16'hF400, 1, 0);
    vecs[4]  = mk(1, 0, 4, 16'h0,    16'hB007, 1, 0);
    vecs[5]  = mk(1, 0, 5, 16'h0,    16'h6007, 1, 0);
    vecs[6]  = mk(1, 0, 6, 16'h0,    16'h4000, 1, 0);
    vecs[7]  = mk(1, 0, 7, 16'h0,    16'h000F, 1, 0);
    vecs[8]  = mk(1, 1, 7, 16'hA5A5, 16'h000F, 0, 0);
    vecs[9]  = mk(1, 0, 7, 16'h0,    16'hA5A5, 1, 0);
    vecs[10] = mk(1, 1, 4, 16'h1234, 16'hA5A5, 0, 1);
    vecs[11] = mk(1, 0, 4, 16'h0,    16'hB007, 1, 0);
    vecs[12] = mk(1, 0, 2, 16'h0,    16'hF800, 1, 0);
    for (int i = 13; i < 18; i++) vecs[i] = mk(0, i[0], 4'(i), 16'hDEAD, 16'hF800, 0, 0);

    rst_n = 1'b0; cs = 0; we = 0; addr = 0; din = 0; plock = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // With the patch feature, lock first so the table's ROM write is refused.
    if (PATCH) cycle(0, 0, 0, 16'h0, 1);

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].c, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0);
      check($sformatf("vec%0d.dout", i),   32'(dout_b), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d.rvalid", i), 32'(rv_b),   32'(vecs[i].e_rv));
      check($sformatf("vec%0d.err", i),    32'(er_b),   32'(vecs[i].e_err));
    end

    // Reset in the middle of a pending write: the write must not land.
    cycle(1, 1, 7, 16'hA5A5, 0);
    cs = 1; we = 1; addr = 7; din = 16'h1111; plock = 0;
    do_reset();
    check("rst.dout",   32'(dout_b), 32'h0);
    check("rst.rvalid", 32'(rv_b),   32'h0);
    cycle(1, 0, 7, 16'h0, 0);
    check("after_rst.rd7", 32'(dout_b), 32'h000F);

    // Out-of-range accesses on the 12-word instance.
    cycle(1, 0, 13, 16'h0, 0);
    check("oor_rd.dout",   32'(dout_s), 32'h0);
    check("oor_rd.rvalid", 32'(rv_s),   32'h1);
    check("oor_rd.err",    32'(er_s),   32'h1);
    cycle(1, 1, 14, 16'hFFFF, 0);
    check("oor_wr.err",    32'(er_s),   32'h1);
    check("oor_wr.rvalid", 32'(rv_s),   32'h0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 4'(i), 16'h0, 0);
    check("oor_wr.rd11", 32'(dout_s), 32'h0);

`ifdef BOOT_PATCH_EN
    cs = 0; we = 0;
    do_reset();
    cycle(1, 1, 1, 16'h0BAD, 0);
    check("patch.wr_err", 32'(er_b), 32'h0);
    cycle(1, 0, 1, 16'h0, 0);
    check("patch.rd1", 32'(dout_b), 32'h0BAD);
    cycle(1, 1, 5, 16'h7777, 1);
    check("patch.wr_lock_same", 32'(er_b), 32'h0);
    cycle(1, 1, 1, 16'hBEEF, 0);
    check("patch.locked_err", 32'(er_b), 32'h1);
    cycle(1, 0, 1, 16'h0, 0);
    check("patch.locked_rd1", 32'(dout_b), 32'h0BAD);
    cycle(1, 0, 5, 16'h0, 0);
    check("patch.rd5", 32'(dout_b), 32'h7777);
    cs = 0; we = 0;
    do_reset();
    cycle(1, 0, 1, 16'h0, 0);
    check("patch.rst_rd1", 32'(dout_b), 32'h4000);
    cycle(1, 1, 2, 16'h2222, 0);
    check("patch.unlocked_err", 32'(er_b), 32'h0);
`endif

    // Random traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 400; n++) begin
      logic c, w, pl;
      c  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      pl = PATCH && ($urandom_range(0, 63) == 0);
      cycle(c, w, 4'($urandom_range(0, 15)), 16'($urandom), pl);
      if (n == 200) begin
        cs = 1; we = 1; addr = 4'($urandom_range(7, 11)); din = 16'hCAFE;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
